// File: rtl/univ_shift_register_if.sv
// Request/status bundle for the universal shift register.
// The master side issues operations; the slave side is the register itself.
interface univ_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_in;
    logic             ser_in_lsb;
    logic             ser_in_msb;
    logic [WIDTH-1:0] data_out;
    logic             ser_out_msb;
    logic             ser_out_lsb;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, count, data_in, ser_in_lsb, ser_in_msb,
        input  data_out, ser_out_msb, ser_out_lsb, busy, done
    );

    modport slave (
        input  start, mode, count, data_in, ser_in_lsb, ser_in_msb,
        output data_out, ser_out_msb, ser_out_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_register.sv
// Multi-step universal shift register: LOAD, logical shifts, rotates and
// arithmetic right shift, one bit per clock, sequenced by an IDLE/SHIFT/DONE FSM.
module univ_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    univ_shift_register_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] MODE_NOP0 = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    logic [1:0]       state_reg, state_next;
    logic [2:0]       mode_reg, mode_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0] data_reg, data_next;

    logic             left_fill;
    logic             right_fill;
    logic [WIDTH-1:0] left_step;
    logic [WIDTH-1:0] right_step;
    logic [WIDTH-1:0] step_value;
    logic             req_is_shift;

    // Fill bits come from the latched mode; serial inputs are taken live each step.
    always_comb begin
        left_fill = bus.ser_in_lsb;
        if (mode_reg == MODE_ROL) begin
            left_fill = data_reg[WIDTH-1];
        end
    end

    always_comb begin
        right_fill = bus.ser_in_msb;
        case (mode_reg)
            MODE_ROR: right_fill = data_reg[0];
            MODE_ASR: right_fill = data_reg[WIDTH-1];
            default:  right_fill = bus.ser_in_msb;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_left_fill
                assign left_step[gi] = left_fill;
            end else begin : g_left_move
                assign left_step[gi] = data_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_right_fill
                assign right_step[gi] = right_fill;
            end else begin : g_right_move
                assign right_step[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        case (mode_reg)
            MODE_SHL, MODE_ROL:           step_value = left_step;
            MODE_SHR, MODE_ROR, MODE_ASR: step_value = right_step;
            default:                      step_value = data_reg;
        endcase
    end

    assign req_is_shift = (bus.mode >= MODE_SHL) && (bus.mode <= MODE_ASR);

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_next = bus.mode;
                    if (bus.mode == MODE_LOAD) begin
                        data_next  = bus.data_in;
                        state_next = ST_DONE;
                    end else if (req_is_shift && (bus.count != '0)) begin
                        remaining_next = bus.count;
                        state_next     = ST_SHIFT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                data_next      = step_value;
                remaining_next = remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_NOP0;
            remaining_reg <= '0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
        end
    end

    assign bus.data_out    = data_reg;
    assign bus.ser_out_msb = data_reg[WIDTH-1];
    assign bus.ser_out_lsb = data_reg[0];
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed bench for univ_shift_register: hand-computed vectors for every mode,
// count edge cases, busy-time start rejection, back-to-back starts and reset abort.
module tb_univ_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] M_NOP  = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_NOP7 = 3'b111;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    univ_shift_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Accept edge of a LOAD, then the DONE cycle, leaving the block idle.
    task automatic do_load(input logic [7:0] val);
        bus.start   = 1'b1;
        bus.mode    = M_LOAD;
        bus.data_in = val;
        tick();
        bus.start = 1'b0;
        check("load_data", bus.data_out, val);
        check("load_done", bus.done, 1);
        tick();
        check("load_idle", bus.busy, 0);
    endtask

    // Accept a shift request; afterwards the block is in SHIFT (or DONE if count=0).
    task automatic issue(input logic [2:0] m, input logic [3:0] c);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.count = c;
        tick();
        bus.start = 1'b0;
    endtask

    // Run the remaining N steps and check the final value and completion pulse.
    task automatic finish_op(input string tag, input int steps, input logic [7:0] exp);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_nodone"}, bus.done, 0);
        for (int i = 0; i < steps; i++) tick();
        check({tag, "_data"}, bus.data_out, exp);
        check({tag, "_done"}, bus.done, 1);
        tick();
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.mode       = M_NOP;
        bus.count      = '0;
        bus.data_in    = '0;
        bus.ser_in_lsb = 1'b0;
        bus.ser_in_msb = 1'b0;
        tick();
        tick();
        check("rst_data", bus.data_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();

        // LOAD 0xAA
        do_load(8'hAA);
        check("aa_msb", bus.ser_out_msb, 1);
        check("aa_lsb", bus.ser_out_lsb, 0);

        // SHL 3 with fill 1: 0x55, 0xAB, 0x57 on successive edges
        bus.ser_in_lsb = 1'b1;
        issue(M_SHL, 4'd3);
        check("shl_accept", bus.data_out, 8'hAA);
        tick(); check("shl_s1", bus.data_out, 8'h55); check("shl_s1_done", bus.done, 0);
        tick(); check("shl_s2", bus.data_out, 8'hAB);
        tick(); check("shl_s3", bus.data_out, 8'h57); check("shl_done", bus.done, 1);
        check("shl_msb", bus.ser_out_msb, 0);
        check("shl_lsb", bus.ser_out_lsb, 1);
        tick(); check("shl_idle", bus.busy, 0);
        bus.ser_in_lsb = 1'b0;

        // ROR 4 from 0xA5 -> 0x5A
        do_load(8'hA5);
        issue(M_ROR, 4'd4);
        finish_op("ror4", 4, 8'h5A);

        // ASR 2 from 0x90 -> 0xE4
        do_load(8'h90);
        issue(M_ASR, 4'd2);
        finish_op("asr2", 2, 8'hE4);

        // ROL 1 from 0x81 -> 0x03
        do_load(8'h81);
        issue(M_ROL, 4'd1);
        finish_op("rol1", 1, 8'h03);

        // SHR 2 with fill 1 from 0x00 -> 0xC0
        do_load(8'h00);
        bus.ser_in_msb = 1'b1;
        issue(M_SHR, 4'd2);
        finish_op("shr2", 2, 8'hC0);
        bus.ser_in_msb = 1'b0;

        // ROR by WIDTH restores; ROL by 15 equals ROL by 7
        do_load(8'h3C);
        issue(M_ROR, 4'd8);
        finish_op("ror8", 8, 8'h3C);
        do_load(8'h01);
        issue(M_ROL, 4'd15);
        finish_op("rol15", 15, 8'h80);

        // Fill bit sampled live at each step: 1,0,1 into 0x00 -> 0x05
        do_load(8'h00);
        bus.ser_in_lsb = 1'b1;
        issue(M_SHL, 4'd3);
        tick(); check("live_s1", bus.data_out, 8'h01);
        bus.ser_in_lsb = 1'b0;
        tick(); check("live_s2", bus.data_out, 8'h02);
        bus.ser_in_lsb = 1'b1;
        tick(); check("live_s3", bus.data_out, 8'h05);
        tick(); check("live_idle", bus.busy, 0);
        bus.ser_in_lsb = 1'b0;

        // count=0 and NOP codes: unchanged, done right after accept
        do_load(8'h5A);
        issue(M_SHL, 4'd0);
        check("cnt0_data", bus.data_out, 8'h5A);
        check("cnt0_done", bus.done, 1);
        tick(); check("cnt0_idle", bus.busy, 0);
        issue(M_NOP, 4'd3);
        check("nop0_data", bus.data_out, 8'h5A);
        check("nop0_done", bus.done, 1);
        tick();
        issue(M_NOP7, 4'd3);
        check("nop7_data", bus.data_out, 8'h5A);
        check("nop7_done", bus.done, 1);
        tick();

        // LOAD request during SHIFT is ignored
        do_load(8'h0F);
        issue(M_SHL, 4'd2);
        tick(); check("busy_s1", bus.data_out, 8'h1E);
        bus.start   = 1'b1;
        bus.mode    = M_LOAD;
        bus.data_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        check("busy_s2", bus.data_out, 8'h3C);
        check("busy_done", bus.done, 1);
        tick();
        check("busy_final", bus.data_out, 8'h3C);
        check("busy_idle", bus.busy, 0);
        tick();
        check("busy_noload", bus.data_out, 8'h3C);

        // Back-to-back: start held re-accepts on the first IDLE cycle
        do_load(8'h01);
        bus.start = 1'b1;
        bus.mode  = M_ROL;
        bus.count = 4'd1;
        tick(); check("b2b_acc1", bus.busy, 1);
        tick(); check("b2b_s1", bus.data_out, 8'h02); check("b2b_done1", bus.done, 1);
        tick(); check("b2b_idle", bus.busy, 0);
        tick(); check("b2b_acc2", bus.busy, 1); check("b2b_acc2_done", bus.done, 0);
        bus.start = 1'b0;
        tick(); check("b2b_s2", bus.data_out, 8'h04); check("b2b_done2", bus.done, 1);
        tick();

        // Reset during 2nd step of SHR 5 aborts with no done pulse
        do_load(8'hF0);
        issue(M_SHR, 4'd5);
        tick(); check("abort_s1", bus.data_out, 8'h78);
        reset = 1'b1;
        tick();
        check("abort_data", bus.data_out, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_nodone", {bus.busy, bus.done}, 0);
        end

        // Reset dominates start on the same edge
        do_load(8'h33);
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.mode    = M_LOAD;
        bus.data_in = 8'h55;
        tick();
        check("rdom_data", bus.data_out, 0);
        check("rdom_busy", bus.busy, 0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        check("rdom_after", bus.data_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
